md_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage. It runs beside the combinational ALU and owns the architectural HI/LO registers.
- Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Latencies and datapath width are parameterised.
- Drives a stall request so the hazard unit holds the EX stage while an operation is in flight, and while an mfhi/mflo would read stale HI/LO.

---
 rtl/md_unit_pkg.sv | 51 +++++
 rtl/md_unit_if.sv | 17 +
 rtl/md_unit_latency_counter.sv | 42 ++++
 rtl/md_unit.sv | 118 +++++++++++
 tb/tb_md_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: md_op encodings and the
// MIPS opcode/funct values the decoder uses to produce md_op and read_hilo.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  function automatic logic is_md_arith(input md_op_e op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

  function automatic md_op_e decode_md_op(input logic [5:0] opcode, input logic [5:0] funct);
    md_op_e op;
    op = MD_NOP;
    if (opcode == OP_SPECIAL) begin
      case (funct)
        FUNCT_MULT:  op = MD_MULT;
        FUNCT_MULTU: op = MD_MULTU;
        FUNCT_DIV:   op = MD_DIV;
        FUNCT_DIVU:  op = MD_DIVU;
        FUNCT_MTHI:  op = MD_MTHI;
        FUNCT_MTLO:  op = MD_MTLO;
        default:     op = MD_NOP;
      endcase
    end
    return op;
  endfunction

  function automatic logic is_hilo_read(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_SPECIAL) && ((funct == FUNCT_MFHI) || (funct == FUNCT_MFLO));
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// EX-stage multiply/divide bus: operands and op in, busy/stall and HI/LO out.
interface md_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] rsdataEX;
  logic [WIDTH-1:0] rtdataEX;
  logic             read_hilo;
  logic             busy;
  logic             md_stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, md_op, rsdataEX, rtdataEX, read_hilo,
                  input  busy, md_stall, hi, lo);
  modport slave  (input  start, md_op, rsdataEX, rtdataEX, read_hilo,
                  output busy, md_stall, hi, lo);
endinterface

// File: rtl/md_unit_latency_counter.sv
// Down-counter that models the fixed latency of an in-flight MD operation;
// done pulses in the last busy cycle so the result commits as busy falls.
module md_unit_latency_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load) begin
      cnt_d  = load_val;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == '0);

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at the
// accept edge and held in pend_* until the latency counter expires.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  md_unit_if.slave   bus
);

  localparam int              PW        = 2 * WIDTH;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  // Returns {hi, lo}; divide-by-zero and MIN/-1 are pinned to defined values.
  function automatic logic [PW-1:0] md_result(input md_op_e op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa, sb, sq, sr;
    logic signed [PW-1:0]    sp;
    logic [PW-1:0]           up;
    logic [WIDTH-1:0]        ones, min_neg;
    ones    = '1;
    min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    sa      = $signed(a);
    sb      = $signed(b);
    sp      = PW'(sa) * PW'(sb);
    up      = PW'(a) * PW'(b);
    sq      = '0;
    sr      = '0;
    md_result = '0;
    case (op)
      MD_MULT:  md_result = sp;
      MD_MULTU: md_result = up;
      MD_DIV: begin
        if (b == '0)                          md_result = {a, ones};
        else if ((a == min_neg) && (b == ones)) md_result = {{WIDTH{1'b0}}, min_neg};
        else begin
          sq        = sa / sb;
          sr        = sa % sb;
          md_result = {sr, sq};
        end
      end
      MD_DIVU: begin
        if (b == '0) md_result = {a, ones};
        else         md_result = {a % b, a / b};
      end
      default: md_result = '0;
    endcase
  endfunction

  md_op_e           op;
  logic             arith_req, accept, idle_start;
  logic             busy, done;
  logic [CNT_W-1:0] load_val;
  logic [PW-1:0]    result;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  always_comb begin
    op         = md_op_e'(bus.md_op);
    arith_req  = bus.start && is_md_arith(op);
    idle_start = bus.start && !busy;
    accept     = arith_req && !busy;
    load_val   = ((op == MD_MULT) || (op == MD_MULTU)) ? MULT_LOAD : DIV_LOAD;
    result     = md_result(op, bus.rsdataEX, bus.rtdataEX);
    hi_d       = hi_q;
    lo_d       = lo_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    if (accept) begin
      pend_hi_d = result[PW-1:WIDTH];
      pend_lo_d = result[WIDTH-1:0];
    end
    if (done) begin
      hi_d = pend_hi_q;
      lo_d = pend_lo_q;
    end else if (idle_start && (op == MD_MTHI)) begin
      hi_d = bus.rsdataEX;
    end else if (idle_start && (op == MD_MTLO)) begin
      lo_d = bus.rsdataEX;
    end
  end

  md_unit_latency_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept),
    .load_val (load_val),
    .busy     (busy),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.md_stall = arith_req || busy || (bus.read_hilo && busy);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed and randomized bench for md_unit against a plain-arithmetic model
// of HI/LO, latency and stall behaviour.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  md_unit_if #(.WIDTH(32)) bus ();

  md_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input int op, input logic [31:0] rs, input logic [31:0] rt);
    longint a, b, q, r;
    logic [63:0] qv, rv;
    a = longint'($signed(rs));
    b = longint'($signed(rt));
    case (op)
      1: return 64'(a * b);
      2: return {32'b0, rs} * {32'b0, rt};
      3: begin
        if (rt == 32'h0) return {rs, 32'hFFFFFFFF};
        if (rs == 32'h80000000 && rt == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q  = a / b;
        r  = a - q * b;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
      end
      4: begin
        if (rt == 32'h0) return {rs, 32'hFFFFFFFF};
        return {rs % rt, rs / rt};
      end
      default: return {exp_hi, exp_lo};
    endcase
  endfunction

  // Issues one instruction in the idle state and follows it to completion.
  task automatic do_op(input int op, input logic [31:0] rs, input logic [31:0] rt, input string tag);
    logic [63:0] r;
    int cyc, lat;
    bus.start = 1'b1; bus.md_op = 3'(op); bus.rsdataEX = rs; bus.rtdataEX = rt;
    #1;
    if (op >= 1 && op <= 4) begin
      chk({tag, "_stall_acc"}, 64'(bus.md_stall), 64'd1);
      r   = model(op, rs, rt);
      lat = (op <= 2) ? MC : DC;
      step();
      bus.start = 1'b0; bus.md_op = 3'd0; bus.read_hilo = 1'b1;
      #1;
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 40) begin
        chk({tag, "_stall_busy"}, 64'(bus.md_stall), 64'd1);
        chk({tag, "_hilo_hold"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
        step();
        cyc++;
      end
      chk({tag, "_latency"}, 64'(cyc), 64'(lat));
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      chk({tag, "_stall_rel"}, 64'(bus.md_stall), 64'd0);
      bus.read_hilo = 1'b0;
    end else begin
      chk({tag, "_stall_mt"}, 64'(bus.md_stall), 64'd0);
      step();
      bus.start = 1'b0; bus.md_op = 3'd0;
      if (op == 5) exp_hi = rs;
      if (op == 6) exp_lo = rs;
      chk({tag, "_busy_mt"}, 64'(bus.busy), 64'd0);
    end
    chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(1, 10));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    logic [63:0] r;
    bus.start = 1'b0; bus.md_op = 3'd0; bus.rsdataEX = '0; bus.rtdataEX = '0; bus.read_hilo = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_stall", 64'(bus.md_stall), 64'd0);

    do_op(1, 32'hFFFFFFFE, 32'd3, "mult");
    chk("mult_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFA);
    do_op(2, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu");
    chk("multu_const", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    do_op(3, 32'hFFFFFFF9, 32'd2, "div");
    chk("div_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(4, 32'd7, 32'd0, "divu0");
    chk("divu0_const", {bus.hi, bus.lo}, 64'h00000007_FFFFFFFF);
    do_op(3, 32'h80000000, 32'hFFFFFFFF, "divovf");
    chk("divovf_const", {bus.hi, bus.lo}, 64'h00000000_80000000);
    do_op(5, 32'h00001234, 32'd0, "mthi");
    chk("mthi_const", {bus.hi, bus.lo}, 64'h00001234_80000000);

    // MTLO arriving in the second busy cycle must be dropped.
    r = model(1, 32'd1000, 32'hFFFFFFF0);
    bus.start = 1'b1; bus.md_op = 3'd1; bus.rsdataEX = 32'd1000; bus.rtdataEX = 32'hFFFFFFF0;
    step();
    bus.start = 1'b0; bus.md_op = 3'd0;
    step();
    bus.start = 1'b1; bus.md_op = 3'd6; bus.rsdataEX = 32'hDEADBEEF;
    #1;
    chk("mtlo_busy_stall", 64'(bus.md_stall), 64'd1);
    step();
    bus.start = 1'b0; bus.md_op = 3'd0;
    chk("mtlo_busy_lo", 64'(bus.lo), 64'(exp_lo));
    cyc = 2;
    while (bus.busy === 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    chk("mtlo_busy_lat", 64'(cyc), 64'(MC));
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    chk("mtlo_busy_res", {bus.hi, bus.lo}, {exp_hi, exp_lo});

    // Reset in the middle of a DIV discards the pending result.
    bus.start = 1'b1; bus.md_op = 3'd3; bus.rsdataEX = 32'd100; bus.rtdataEX = 32'd7;
    step();
    bus.start = 1'b0; bus.md_op = 3'd0;
    step(); step(); step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    chk("rstmid_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rstmid_busy", 64'(bus.busy), 64'd0);
    repeat (12) step();
    chk("rstmid_late_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rstmid_late_busy", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 60; i++) begin
      do_op(int'($urandom_range(1, 6)), pick(), pick(), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
